sound_sched: RTL and testbench
==============================

Name: sound_sched

Overview:
Speaker scheduler for the Simon game. Shares one square-wave tone generator between four requesters: live lamp echo, win jingle, lose jingle and high-score jingle. It arbitrates by fixed priority, sequences the multi-note jingles and drives the single speaker pin. It sits beside the game controller and receives copies of the lamp bus and the win, lose and high-score events.

Parameters:
NOTE_CYCLES, 5_000_000, clock cycles per jingle note (100 ms at 50 MHz); legal range ≥ 1.
TONE_DIV_SHIFT, 0, right-shift applied to every half-period table entry (sim speed-up); result clamped to a minimum of 1.

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
LAMP  in  2  lamp index from the controller
LAMP_ENA  in  1  lamp lit; lamp echo requested
WIN_REQ  in  1  one-cycle pulse; start win jingle
LOSE_REQ  in  1  one-cycle pulse; start lose jingle
HS_REQ  in  1  one-cycle pulse; start high-score jingle
MUTE  in  1  force SPK low; sequencing continues
SPK  out  1  speaker square wave
TONE  out  3  current tone index (0 = silence)
BUSY  out  1  jingle in progress
DONE  out  1  one-cycle pulse at natural jingle completion

Behaviour:
- One clock (CLK), asynchronous active-high reset (RST).
- Reset, asynchronous: state=IDLE, TONE=0, SPK=0, BUSY=0, DONE=0, note index=0, note timer=0, phase counter=0.
- Tone table, 17-bit half-periods at 50 MHz:
  - 1=60241 (415 Hz), 2=80645 (310 Hz), 3=99206 (252 Hz), 4=119617 (209 Hz)
  - 5=47801 (523 Hz), 6=37936 (659 Hz), 7=31888 (784 Hz)
  - Effective HP = max(1, table>>TONE_DIV_SHIFT).
- Jingle ROMs, 4 notes each, played in order:
  - WIN = 5,6,7,7
  - LOSE = 4,3,2,1
  - HS = 5,7,5,7
- Priority: LOSE > WIN > HS > lamp.
- State IDLE/LAMP (BUSY=0): TONE is registered each cycle as LAMP_ENA ? LAMP+1 : 0. A request registered in a cycle moves to JINGLE on the next edge.
- State JINGLE (BUSY=1):
  - TONE = ROM[jingle][note]. The note timer counts 0..NOTE_CYCLES-1, then the note index advances.
  - After note 3 expires: DONE=1 for exactly one cycle, BUSY=0, and the block returns to lamp echo on that same edge.
  - LAMP_ENA is ignored throughout a jingle.
- Latency: a request pulse sampled at edge t gives TONE=note0 and BUSY=1 after edge t+1. Each note lasts exactly NOTE_CYCLES cycles.
- Simultaneous requests in one cycle: the highest priority wins; the others are dropped, not queued.
- Request while in JINGLE:
  - Strictly higher priority: preempt, restart at note 0 of the new jingle. No DONE for the aborted jingle.
  - Equal priority: restart the same jingle at note 0.
  - Lower priority: dropped.
- Tone generator: on any change of TONE, the phase counter is cleared and SPK is forced to 0.
  - Otherwise, when TONE≠0, the counter counts 0..HP-1. At HP-1 it wraps and SPK toggles.
  - So the first SPK rise occurs HP cycles after TONE changes, and the period is 2·HP.
  - TONE=0 holds SPK=0 and the counter at 0.
- MUTE: gates only the SPK output (SPK=raw&!MUTE). The counters, TONE, BUSY and DONE are unaffected.
- RST mid-jingle: immediate return to reset values. No DONE.

Decomposition:
- Package sound_pkg holds:
  - tone_t (3-bit) and the TONE_HALF[1:7] constant array
  - jingle_t enum {J_WIN, J_LOSE, J_HS}
  - the JINGLE_ROM constant (3×4 tone_t)
  - JINGLE_LEN=4
  - state enum {S_IDLE, S_JINGLE}
- One sub-module, tone_gen: takes TONE in and produces raw SPK, covering the phase counter and half-period lookup.
- sound_sched itself covers arbitration, note sequencing and the MUTE gate.

Test Plan:
- All tests use TONE_DIV_SHIFT=10 (HP: 1=58, 2=78, 3=96, 4=116, 5=46, 6=37, 7=31) and NOTE_CYCLES=200.
- Reset, then LAMP=2, LAMP_ENA=1 → TONE=3 after 1 edge. SPK rises 96 cycles later with period 192. Dropping LAMP_ENA → TONE=0 and SPK=0 next edge.
- WIN_REQ pulse → BUSY=1. TONE sequence 5,6,7,7, each held 200 cycles. DONE is high for 1 cycle at cycle 801 after the request, then BUSY=0.
- HS_REQ and LOSE_REQ in the same cycle → the LOSE sequence 4,3,2,1 plays. The HS request is lost; exactly one DONE.
- WIN playing at note 2, then LOSE_REQ → TONE=4 next edge, note 0 of LOSE, no DONE for WIN.
- WIN playing, then HS_REQ → ignored; WIN completes normally.
- WIN playing, then WIN_REQ → WIN restarts at note 0.
- MUTE=1 during a lamp tone → SPK=0 while TONE is unchanged. Asserting RST mid-jingle → all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constant tables for the Simon speaker scheduler:
// tone half-periods, jingle note ROMs and arbitration priority.
package sound_pkg;

    typedef logic [2:0] tone_t;

    // Half-periods in 50 MHz clock cycles; index 0 means silence and has no entry.
    localparam logic [16:0] TONE_HALF [1:7] = '{
        17'd60241, 17'd80645, 17'd99206, 17'd119617,
        17'd47801, 17'd37936, 17'd31888
    };

    typedef enum logic [1:0] {J_WIN, J_LOSE, J_HS} jingle_t;

    localparam int JINGLE_LEN = 4;

    localparam tone_t JINGLE_ROM [3][JINGLE_LEN] = '{
        '{3'd5, 3'd6, 3'd7, 3'd7},
        '{3'd4, 3'd3, 3'd2, 3'd1},
        '{3'd5, 3'd7, 3'd5, 3'd7}
    };

    typedef enum logic {S_IDLE, S_JINGLE} state_t;

    // Larger value wins: LOSE > WIN > HS.
    function automatic logic [1:0] jingle_prio(jingle_t j);
        case (j)
            J_LOSE:  return 2'd2;
            J_WIN:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sound_sched_tone_gen.sv
// Square-wave generator: half-period lookup plus phase counter that
// restarts from a low level whenever the selected tone changes.
module tone_gen
    import sound_pkg::*;
#(
    parameter int TONE_DIV_SHIFT = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  tone_t tone,
    input  logic  restart,
    output logic  spk
);

    logic [16:0] phase_cnt;
    logic [16:0] half_p;

    // Scaled half-period, clamped so a heavy sim speed-up never yields zero.
    function automatic logic [16:0] sat_half(tone_t t);
        logic [16:0] scaled;
        if (t == 3'd0) return 17'd1;
        scaled = TONE_HALF[t] >> TONE_DIV_SHIFT;
        return (scaled == 17'd0) ? 17'd1 : scaled;
    endfunction

    always_comb half_p = sat_half(tone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
            spk       <= 1'b0;
        end else if (restart || tone == 3'd0) begin
            phase_cnt <= '0;
            spk       <= 1'b0;
        end else if (phase_cnt == half_p - 17'd1) begin
            phase_cnt <= '0;
            spk       <= ~spk;
        end else begin
            phase_cnt <= phase_cnt + 17'd1;
        end
    end

endmodule

// File: rtl/sound_sched.sv
// Speaker scheduler: fixed-priority arbitration between lamp echo and three
// jingles, note sequencing, and the output mute gate.
module sound_sched
    import sound_pkg::*;
#(
    parameter int NOTE_CYCLES    = 5_000_000,
    parameter int TONE_DIV_SHIFT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] LAMP,
    input  logic       LAMP_ENA,
    input  logic       WIN_REQ,
    input  logic       LOSE_REQ,
    input  logic       HS_REQ,
    input  logic       MUTE,
    output logic       SPK,
    output logic [2:0] TONE,
    output logic       BUSY,
    output logic       DONE
);

    localparam int TMR_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(NOTE_CYCLES - 1);

    state_t           state, state_nxt;
    jingle_t          jin, jin_nxt;
    logic [1:0]       note_idx, note_idx_nxt;
    logic [TMR_W-1:0] note_tmr, note_tmr_nxt;
    tone_t            tone_nxt;
    logic             done_nxt;
    logic             req_any;
    jingle_t          req_sel;
    logic             req_vld_p0;
    jingle_t          req_jin_p0;
    logic             start;
    logic             spk_raw;

    always_comb begin
        req_any = WIN_REQ | LOSE_REQ | HS_REQ;
        if (LOSE_REQ)     req_sel = J_LOSE;
        else if (WIN_REQ) req_sel = J_WIN;
        else              req_sel = J_HS;
    end

    // Stage p0: winning request of this cycle, acted on at the next edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            jin        <= J_WIN;
            note_idx   <= '0;
            note_tmr   <= '0;
            TONE       <= '0;
            DONE       <= 1'b0;
            req_vld_p0 <= 1'b0;
            req_jin_p0 <= J_WIN;
        end else begin
            state      <= state_nxt;
            jin        <= jin_nxt;
            note_idx   <= note_idx_nxt;
            note_tmr   <= note_tmr_nxt;
            TONE       <= tone_nxt;
            DONE       <= done_nxt;
            req_vld_p0 <= req_any;
            req_jin_p0 <= req_sel;
        end
    end

    // Equal priority restarts the running jingle; lower priority is dropped.
    always_comb begin
        start = req_vld_p0 &&
                (state == S_IDLE || jingle_prio(req_jin_p0) >= jingle_prio(jin));
        state_nxt    = state;
        jin_nxt      = jin;
        note_idx_nxt = note_idx;
        note_tmr_nxt = note_tmr;
        done_nxt     = 1'b0;
        if (start) begin
            state_nxt    = S_JINGLE;
            jin_nxt      = req_jin_p0;
            note_idx_nxt = '0;
            note_tmr_nxt = '0;
        end else if (state == S_JINGLE) begin
            if (note_tmr == TMR_LAST) begin
                note_tmr_nxt = '0;
                if (note_idx == 2'(JINGLE_LEN - 1)) begin
                    state_nxt    = S_IDLE;
                    note_idx_nxt = '0;
                    done_nxt     = 1'b1;
                end else begin
                    note_idx_nxt = note_idx + 2'd1;
                end
            end else begin
                note_tmr_nxt = note_tmr + TMR_W'(1);
            end
        end
        if (state_nxt == S_JINGLE)
            tone_nxt = JINGLE_ROM[jin_nxt][note_idx_nxt];
        else
            tone_nxt = LAMP_ENA ? ({1'b0, LAMP} + 3'd1) : 3'd0;
    end

    always_comb begin
        BUSY = (state == S_JINGLE);
        SPK  = spk_raw & ~MUTE;
    end

    tone_gen #(
        .TONE_DIV_SHIFT(TONE_DIV_SHIFT)
    ) u_tone_gen (
        .clk     (CLK),
        .rst     (RST),
        .tone    (TONE),
        .restart (tone_nxt != TONE),
        .spk     (spk_raw)
    );

endmodule

// File: tb/tb_sound_sched.sv
// Bench for sound_sched: lamp vector table, tone timing, and jingle
// sequences checked cycle by cycle against a queue of expected outputs.
module tb_sound_sched;

    localparam int NC = 200;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] LAMP = 2'd0;
    logic       LAMP_ENA = 1'b0;
    logic       WIN_REQ = 1'b0;
    logic       LOSE_REQ = 1'b0;
    logic       HS_REQ = 1'b0;
    logic       MUTE = 1'b0;
    logic       SPK;
    logic [2:0] TONE;
    logic       BUSY;
    logic       DONE;

    always #5 CLK = ~CLK;

    sound_sched #(
        .NOTE_CYCLES   (NC),
        .TONE_DIV_SHIFT(10)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .LAMP    (LAMP),
        .LAMP_ENA(LAMP_ENA),
        .WIN_REQ (WIN_REQ),
        .LOSE_REQ(LOSE_REQ),
        .HS_REQ  (HS_REQ),
        .MUTE    (MUTE),
        .SPK     (SPK),
        .TONE    (TONE),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    typedef struct {
        logic [2:0] tone;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic [1:0] lamp;
        logic       ena;
        logic       mute;
        logic [2:0] exp_tone;
        logic       exp_spk;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[7];
    int    checks = 0;
    int    errors = 0;
    int    done_seen = 0;
    string phase = "reset";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic b, input logic d, input int n);
        for (int i = 0; i < n; i++) sb.push_back('{t, b, d});
    endtask

    task automatic step();
        exp_t e;
        tick();
        if (DONE === 1'b1) done_seen++;
        if (sb.size() == 0) begin
            chk({phase, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({phase, " TONE"}, 32'(TONE), 32'(e.tone));
            chk({phase, " BUSY"}, 32'(BUSY), 32'(e.busy));
            chk({phase, " DONE"}, 32'(DONE), 32'(e.done));
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step();
    endtask

    // Full 4-note jingle followed by the DONE cycle and a short idle tail.
    task automatic push_full(input logic [2:0] n0, input logic [2:0] n1,
                             input logic [2:0] n2, input logic [2:0] n3,
                             input logic [2:0] after);
        push(n0, 1'b1, 1'b0, NC);
        push(n1, 1'b1, 1'b0, NC);
        push(n2, 1'b1, 1'b0, NC);
        push(n3, 1'b1, 1'b0, NC);
        push(after, 1'b0, 1'b1, 1);
        push(after, 1'b0, 1'b0, 3);
    endtask

    initial begin
        int n;
        int d0;

        vecs[0] = '{2'd2, 1'b1, 1'b0, 3'd3, 1'b0};
        vecs[1] = '{2'd0, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[2] = '{2'd3, 1'b1, 1'b0, 3'd4, 1'b0};
        vecs[3] = '{2'd3, 1'b1, 1'b1, 3'd4, 1'b0};
        vecs[4] = '{2'd1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[5] = '{2'd1, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[6] = '{2'd1, 1'b0, 1'b0, 3'd0, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset TONE", 32'(TONE), 32'd0);
        chk("reset SPK", 32'(SPK), 32'd0);
        chk("reset BUSY", 32'(BUSY), 32'd0);
        chk("reset DONE", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;

        phase = "lamp table";
        for (int i = 0; i < 7; i++) begin
            LAMP = vecs[i].lamp;
            LAMP_ENA = vecs[i].ena;
            MUTE = vecs[i].mute;
            push(vecs[i].exp_tone, 1'b0, 1'b0, 1);
            step();
            chk("lamp table SPK", 32'(SPK), 32'(vecs[i].exp_spk));
        end
        MUTE = 1'b0;

        phase = "lamp timing";
        LAMP = 2'd2;
        LAMP_ENA = 1'b1;
        push(3'd3, 1'b0, 1'b0, 1);
        step();
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            n = k;
            if (SPK === 1'b1) break;
        end
        chk("lamp first rise cycles", 32'(n), 32'd96);
        MUTE = 1'b1;
        #1;
        chk("mute SPK", 32'(SPK), 32'd0);
        chk("mute TONE", 32'(TONE), 32'd3);
        MUTE = 1'b0;
        #1;
        chk("unmute SPK", 32'(SPK), 32'd1);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            n = k;
            if (SPK === 1'b0) break;
        end
        chk("lamp half period cycles", 32'(n), 32'd96);
        LAMP_ENA = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1);
        step();
        chk("lamp off SPK", 32'(SPK), 32'd0);

        // Lamp held on throughout the jingle must not override the notes.
        phase = "win";
        LAMP = 2'd0;
        LAMP_ENA = 1'b1;
        push(3'd1, 1'b0, 1'b0, 1);
        step();
        d0 = done_seen;
        push(3'd1, 1'b0, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push_full(3'd5, 3'd6, 3'd7, 3'd7, 3'd1);
        drain();
        chk("win DONE count", 32'(done_seen - d0), 32'd1);

        phase = "lose+hs";
        LAMP_ENA = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1);
        step();
        d0 = done_seen;
        push(3'd0, 1'b0, 1'b0, 1);
        HS_REQ = 1'b1;
        LOSE_REQ = 1'b1;
        step();
        HS_REQ = 1'b0;
        LOSE_REQ = 1'b0;
        push_full(3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
        push(3'd0, 1'b0, 1'b0, 20);
        drain();
        chk("lose+hs DONE count", 32'(done_seen - d0), 32'd1);

        phase = "preempt";
        d0 = done_seen;
        push(3'd0, 1'b0, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push(3'd5, 1'b1, 1'b0, NC);
        push(3'd6, 1'b1, 1'b0, NC);
        push(3'd7, 1'b1, 1'b0, 49);
        drain();
        push(3'd7, 1'b1, 1'b0, 1);
        LOSE_REQ = 1'b1;
        step();
        LOSE_REQ = 1'b0;
        push_full(3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
        drain();
        chk("preempt DONE count", 32'(done_seen - d0), 32'd1);

        phase = "hs ignored";
        push(3'd0, 1'b0, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push(3'd5, 1'b1, 1'b0, 99);
        drain();
        push(3'd5, 1'b1, 1'b0, 1);
        HS_REQ = 1'b1;
        step();
        HS_REQ = 1'b0;
        push(3'd5, 1'b1, 1'b0, NC - 100);
        push(3'd6, 1'b1, 1'b0, NC);
        push(3'd7, 1'b1, 1'b0, NC);
        push(3'd7, 1'b1, 1'b0, NC);
        push(3'd0, 1'b0, 1'b1, 1);
        push(3'd0, 1'b0, 1'b0, 3);
        drain();

        phase = "win restart";
        push(3'd0, 1'b0, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push(3'd5, 1'b1, 1'b0, NC);
        push(3'd6, 1'b1, 1'b0, 99);
        drain();
        push(3'd6, 1'b1, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push_full(3'd5, 3'd6, 3'd7, 3'd7, 3'd0);
        drain();

        // Note 5 has HP 46, so SPK is high from cycle 47 to 92 of the note.
        phase = "reset mid-jingle";
        LAMP = 2'd3;
        LAMP_ENA = 1'b1;
        push(3'd4, 1'b0, 1'b0, 1);
        step();
        push(3'd4, 1'b0, 1'b0, 1);
        WIN_REQ = 1'b1;
        step();
        WIN_REQ = 1'b0;
        push(3'd5, 1'b1, 1'b0, 60);
        drain();
        chk("jingle SPK high before reset", 32'(SPK), 32'd1);
        d0 = done_seen;
        #2;
        RST = 1'b1;
        #1;
        chk("async reset TONE", 32'(TONE), 32'd0);
        chk("async reset SPK", 32'(SPK), 32'd0);
        chk("async reset BUSY", 32'(BUSY), 32'd0);
        chk("async reset DONE", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        push(3'd4, 1'b0, 1'b0, 5);
        drain();
        chk("reset mid-jingle DONE count", 32'(done_seen - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
